// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Frame layout: SOF, CMD (bit7 write, bits3:0 address), DATA, CHK = CMD ^ DATA.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        GET_CMD,
        GET_DATA,
        GET_CHK,
        EXEC,
        SEND_ACK,
        SEND_DATA,
        SEND_NAK
    } state_t;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int CMD_WR_BIT    = 7;
    localparam int CMD_ADDR_MSB  = 3;
    localparam int CMD_ADDR_LSB  = 0;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of RX FIFO, TX FIFO, register bank and status signals around the
// command sequencer; master is the sequencer, slave is its surroundings.
interface uart_cmd_ctrl_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx_empty, r_data, tx_full, reg_rdata,
        output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, frame_err, busy
    );

    modport slave (
        output rx_empty, r_data, tx_full, reg_rdata,
        input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, frame_err, busy
    );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Loadable inter-byte down-counter; expired fires on the CYCLES-th enabled
// cycle after the last load.
module uart_cmd_timeout #(
    parameter int CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = enable && !load && (count == '0);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed command sequencer: RX FIFO -> checksum -> register read/write -> ACK/NAK on TX FIFO.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SOF            = SOF_BYTE,
    parameter logic [7:0] ACK            = ACK_BYTE,
    parameter logic [7:0] NAK            = NAK_BYTE,
    parameter int         TIMEOUT_CYCLES = 5_000_000
) (
    input  logic            clk,
    input  logic            reset,
    uart_cmd_ctrl_if.master bus
);
    state_t     state, state_nxt;
    logic [7:0] cmd_q, data_q, resp_q;
    logic [3:0] addr_q;
    logic       pop, push, nak_pulse, timeout_hit, chk_ok;
    logic [7:0] tx_byte;

    assign chk_ok = (bus.r_data == frame_chk(cmd_q, data_q));

`ifdef UART_CMD_TIMEOUT_EN
    logic timer_run;

    assign timer_run = (state == GET_CMD) || (state == GET_DATA) || (state == GET_CHK);

    // Every pop reloads; junk pops in HUNT reload too but the timer is idle there.
    uart_cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (pop),
        .enable  (timer_run),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= HUNT;
            cmd_q  <= '0;
            data_q <= '0;
            resp_q <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == GET_CMD && pop) begin
                cmd_q <= bus.r_data;
            end
            if (state == GET_DATA && pop) begin
                data_q <= bus.r_data;
            end
            // Address is presented during EXEC so the combinational read data is valid there.
            if (state == GET_CHK && pop && chk_ok) begin
                addr_q <= cmd_q[CMD_ADDR_MSB:CMD_ADDR_LSB];
            end
            if (state == EXEC) begin
                resp_q <= cmd_q[CMD_WR_BIT] ? data_q : bus.reg_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        nak_pulse = 1'b0;
        tx_byte   = 8'h00;
        case (state)
            HUNT: begin
                if (!bus.rx_empty) begin
                    pop = 1'b1;
                    if (bus.r_data == SOF) begin
                        state_nxt = GET_CMD;
                    end
                end
            end
            GET_CMD: begin
                if (!bus.rx_empty) begin
                    pop       = 1'b1;
                    state_nxt = GET_DATA;
                end
            end
            GET_DATA: begin
                if (!bus.rx_empty) begin
                    pop       = 1'b1;
                    state_nxt = GET_CHK;
                end
            end
            GET_CHK: begin
                if (!bus.rx_empty) begin
                    pop       = 1'b1;
                    state_nxt = chk_ok ? EXEC : SEND_NAK;
                end
            end
            EXEC: begin
                state_nxt = SEND_ACK;
            end
            SEND_ACK: begin
                if (!bus.tx_full) begin
                    push      = 1'b1;
                    tx_byte   = ACK;
                    state_nxt = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (!bus.tx_full) begin
                    push      = 1'b1;
                    tx_byte   = resp_q;
                    state_nxt = HUNT;
                end
            end
            SEND_NAK: begin
                if (!bus.tx_full) begin
                    push      = 1'b1;
                    nak_pulse = 1'b1;
                    tx_byte   = NAK;
                    state_nxt = HUNT;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
        if (timeout_hit) begin
            state_nxt = HUNT;
        end
    end

    assign bus.rd_uart   = pop;
    assign bus.wr_uart   = push;
    assign bus.w_data    = tx_byte;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = data_q;
    assign bus.reg_we    = (state == EXEC) && cmd_q[CMD_WR_BIT];
    assign bus.frame_err = nak_pulse || timeout_hit;
    assign bus.busy      = (state != HUNT);
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl; the timeout scenario is compiled only
// when UART_CMD_TIMEOUT_EN is defined (the DUT is built with a 100-cycle timeout).
module tb_uart_cmd_ctrl;
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } we_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_full = 1'b0;
    logic rd_ovr_en = 1'b0;
    logic [7:0] rd_ovr = 8'h00;

    logic [7:0] rx_mem [0:1023];
    int rx_wr = 0;
    int rx_rd = 0;
    logic [7:0] regs [0:15];

    int cyc = 0;
    int last_pop_cyc = 0;
    int ferr_cyc = 0;
    int ferr_cnt = 0;
    int rd_viol = 0;
    int wr_viol = 0;

    logic [7:0] tx_obs [$];
    int         tx_cyc [$];
    we_t        we_obs [$];
    logic [7:0] exp_tx [$];
    we_t        exp_we [$];

    int vectors = 0;
    int errors = 0;

    uart_cmd_ctrl_if bus ();

    assign bus.rx_empty  = (rx_rd == rx_wr);
    assign bus.r_data    = rx_mem[rx_rd];
    assign bus.tx_full   = tx_full;
    assign bus.reg_rdata = rd_ovr_en ? rd_ovr : regs[bus.reg_addr];

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (!reset) begin
            cyc <= cyc + 1;
            if (bus.rd_uart) begin
                if (bus.rx_empty) rd_viol <= rd_viol + 1;
                rx_rd <= rx_rd + 1;
                last_pop_cyc <= cyc;
            end
            if (bus.wr_uart) begin
                if (tx_full) wr_viol <= wr_viol + 1;
                tx_obs.push_back(bus.w_data);
                tx_cyc.push_back(cyc);
            end
            if (bus.reg_we) begin
                we_obs.push_back({bus.reg_addr, bus.reg_wdata});
                regs[bus.reg_addr] <= bus.reg_wdata;
            end
            if (bus.frame_err) begin
                ferr_cnt <= ferr_cnt + 1;
                ferr_cyc <= cyc;
            end
        end
    end

    task automatic put_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        rx_mem[rx_wr] = b0;
        rx_mem[rx_wr + 1] = b1;
        rx_mem[rx_wr + 2] = b2;
        rx_mem[rx_wr + 3] = b3;
        rx_wr = rx_wr + 4;
    endtask

    task automatic clear_obs();
        tx_obs.delete();
        tx_cyc.delete();
        we_obs.delete();
        exp_tx.delete();
        exp_we.delete();
        ferr_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rx_rd == rx_wr && !bus.busy) && n < 300);
        if (n >= 300) begin
            vectors++;
            errors++;
            $display("FAIL %s idle_wait: still busy after %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.rd_uart, bus.wr_uart, bus.reg_we, bus.frame_err, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 00000",
                     {bus.rd_uart, bus.wr_uart, bus.reg_we, bus.frame_err, bus.busy});
        end
        vectors++;
        if ({bus.w_data, bus.reg_wdata, bus.reg_addr} !== 20'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000", {bus.w_data, bus.reg_wdata, bus.reg_addr});
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_write();
        clear_obs();
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'h5C);
        exp_we.push_back({4'h3, 8'h5C});
        put_frame(8'hA5, 8'h83, 8'h5C, 8'hDF);
        wait_idle("write");
        vectors++;
        if (tx_cyc.size() < 1 || tx_cyc[0] - last_pop_cyc != 2) begin
            errors++;
            $display("FAIL write_latency got %0d exp 2",
                     tx_cyc.size() > 0 ? tx_cyc[0] - last_pop_cyc : -1);
        end
        vectors++;
        if (tx_obs.size() != exp_tx.size() || we_obs.size() != exp_we.size()) begin
            errors++;
            $display("FAIL write_counts got tx=%0d we=%0d exp tx=%0d we=%0d",
                     tx_obs.size(), we_obs.size(), exp_tx.size(), exp_we.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL write_tx got %h exp %h", g, e);
            end
        end
        while (we_obs.size() > 0 && exp_we.size() > 0) begin
            we_t g, e;
            g = we_obs.pop_front();
            e = exp_we.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL write_reg got addr=%h data=%h exp addr=%h data=%h", g.a, g.d, e.a, e.d);
            end
        end
        vectors++;
        if (ferr_cnt != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL write_status got ferr=%0d busy=%b exp ferr=0 busy=0", ferr_cnt, bus.busy);
        end
    endtask

    task automatic test_read();
        clear_obs();
        rd_ovr_en = 1'b1;
        rd_ovr = 8'h7E;
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'h7E);
        put_frame(8'hA5, 8'h02, 8'h00, 8'h02);
        wait_idle("read");
        rd_ovr_en = 1'b0;
        vectors++;
        if (we_obs.size() != 0 || tx_obs.size() != exp_tx.size()) begin
            errors++;
            $display("FAIL read_counts got tx=%0d we=%0d exp tx=%0d we=0",
                     tx_obs.size(), we_obs.size(), exp_tx.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL read_tx got %h exp %h", g, e);
            end
        end
    endtask

    task automatic test_bad_chk();
        clear_obs();
        exp_tx.push_back(8'h15);
        put_frame(8'hA5, 8'h83, 8'h5C, 8'h00);
        wait_idle("bad_chk");
        vectors++;
        if (we_obs.size() != 0 || ferr_cnt != 1 || tx_obs.size() != exp_tx.size()) begin
            errors++;
            $display("FAIL nak_counts got we=%0d ferr=%0d tx=%0d exp we=0 ferr=1 tx=%0d",
                     we_obs.size(), ferr_cnt, tx_obs.size(), exp_tx.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL nak_tx got %h exp %h", g, e);
            end
        end
    endtask

    task automatic test_junk();
        clear_obs();
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'h11);
        exp_we.push_back({4'hA, 8'h11});
        rx_mem[rx_wr] = 8'h00;
        rx_mem[rx_wr + 1] = 8'hFF;
        rx_mem[rx_wr + 2] = 8'h13;
        rx_wr = rx_wr + 3;
        put_frame(8'hA5, 8'h8A, 8'h11, 8'h9B);
        wait_idle("junk");
        vectors++;
        if (rx_rd != rx_wr || tx_obs.size() != exp_tx.size() || we_obs.size() != 1) begin
            errors++;
            $display("FAIL junk_counts got left=%0d tx=%0d we=%0d exp left=0 tx=%0d we=1",
                     rx_wr - rx_rd, tx_obs.size(), we_obs.size(), exp_tx.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL junk_tx got %h exp %h", g, e);
            end
        end
        if (we_obs.size() > 0) begin
            we_t g;
            g = we_obs.pop_front();
            vectors++;
            if (g !== exp_we[0]) begin
                errors++;
                $display("FAIL junk_reg got %h exp %h", g, exp_we[0]);
            end
        end
    endtask

    task automatic test_tx_stall();
        int n;
        int rel_cyc;
        clear_obs();
        rd_ovr_en = 1'b1;
        rd_ovr = 8'hC3;
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'hC3);
        tx_full = 1'b1;
        put_frame(8'hA5, 8'h04, 8'h00, 8'h04);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_rd != rx_wr && n < 50);
        repeat (21) @(negedge clk);
        vectors++;
        if (tx_obs.size() != 0 || !bus.busy) begin
            errors++;
            $display("FAIL stall_hold got tx=%0d busy=%b exp tx=0 busy=1", tx_obs.size(), bus.busy);
        end
        tx_full = 1'b0;
        rel_cyc = cyc;
        wait_idle("stall");
        rd_ovr_en = 1'b0;
        vectors++;
        if (tx_cyc.size() < 1 || tx_cyc[0] != rel_cyc || wr_viol != 0) begin
            errors++;
            $display("FAIL stall_release got ack_cyc=%0d viol=%0d exp ack_cyc=%0d viol=0",
                     tx_cyc.size() > 0 ? tx_cyc[0] : -1, wr_viol, rel_cyc);
        end
        vectors++;
        if (tx_obs.size() != exp_tx.size()) begin
            errors++;
            $display("FAIL stall_count got %0d exp %0d", tx_obs.size(), exp_tx.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL stall_tx got %h exp %h", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        exp_tx.push_back(8'h06); exp_tx.push_back(8'hAA);
        exp_tx.push_back(8'h06); exp_tx.push_back(8'hAA);
        exp_tx.push_back(8'h06); exp_tx.push_back(8'hA5);
        exp_we.push_back({4'h1, 8'hAA});
        exp_we.push_back({4'h5, 8'hA5});
        put_frame(8'hA5, 8'h81, 8'hAA, 8'h2B);
        put_frame(8'hA5, 8'h01, 8'h00, 8'h01);
        put_frame(8'hA5, 8'h85, 8'hA5, 8'h20);
        wait_idle("b2b");
        vectors++;
        if (tx_obs.size() != exp_tx.size() || we_obs.size() != exp_we.size()) begin
            errors++;
            $display("FAIL b2b_counts got tx=%0d we=%0d exp tx=%0d we=%0d",
                     tx_obs.size(), we_obs.size(), exp_tx.size(), exp_we.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_tx got %h exp %h", g, e);
            end
        end
        while (we_obs.size() > 0 && exp_we.size() > 0) begin
            we_t g, e;
            g = we_obs.pop_front();
            e = exp_we.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL b2b_reg got %h exp %h", g, e);
            end
        end
        vectors++;
        if (rd_viol != 0 || wr_viol != 0) begin
            errors++;
            $display("FAIL strobe_rules got rd_viol=%0d wr_viol=%0d exp 0 0", rd_viol, wr_viol);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_obs();
        rx_mem[rx_wr] = 8'hA5;
        rx_mem[rx_wr + 1] = 8'h86;
        rx_wr = rx_wr + 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_rd != rx_wr && n < 50);
        vectors++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got busy=%b exp 1", bus.busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || tx_obs.size() != 0 || we_obs.size() != 0) begin
            errors++;
            $display("FAIL midreset_post got busy=%b tx=%0d we=%0d exp busy=0 tx=0 we=0",
                     bus.busy, tx_obs.size(), we_obs.size());
        end
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        clear_obs();
        rx_mem[rx_wr] = 8'hA5;
        rx_mem[rx_wr + 1] = 8'h83;
        rx_wr = rx_wr + 2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rx_rd != rx_wr && n < 50);
        repeat (150) @(negedge clk);
        vectors++;
        if (ferr_cnt != 1 || ferr_cyc - last_pop_cyc != 100) begin
            errors++;
            $display("FAIL timeout_pulse got count=%0d delay=%0d exp count=1 delay=100",
                     ferr_cnt, ferr_cyc - last_pop_cyc);
        end
        vectors++;
        if (bus.busy !== 1'b0 || tx_obs.size() != 0) begin
            errors++;
            $display("FAIL timeout_state got busy=%b tx=%0d exp busy=0 tx=0", bus.busy, tx_obs.size());
        end
        clear_obs();
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'h3C);
        put_frame(8'hA5, 8'h87, 8'h3C, 8'hBB);
        wait_idle("timeout_next");
        vectors++;
        if (tx_obs.size() != exp_tx.size() || ferr_cnt != 0) begin
            errors++;
            $display("FAIL timeout_next got tx=%0d ferr=%0d exp tx=%0d ferr=0",
                     tx_obs.size(), ferr_cnt, exp_tx.size());
        end
        while (tx_obs.size() > 0 && exp_tx.size() > 0) begin
            logic [7:0] g, e;
            g = tx_obs.pop_front();
            e = exp_tx.pop_front();
            vectors++;
            if (g !== e) begin
                errors++;
                $display("FAIL timeout_tx got %h exp %h", g, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_chk();
        test_junk();
        test_tx_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_write();
`ifdef UART_CMD_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART RX/TX FIFOs and a 16-entry 8-bit control register bank (brightness, warn thresholds, LED modes). It pops framed command bytes from the RX FIFO, validates a checksum, performs one register read or write, and pushes an ACK or NAK response into the TX FIFO. It replaces the raw echo path in the top level once the link is proven.

Parameters:
- SOF, 8'hA5, start-of-frame byte.
- ACK, 8'h06, response code for a good frame.
- NAK, 8'h15, response code for a bad checksum.
- TIMEOUT_CYCLES, 5_000_000, inter-byte timeout in clk cycles (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- rx_empty  in  1  RX FIFO empty.
- r_data  in  8  RX FIFO head byte; valid whenever rx_empty=0.
- rd_uart  out  1  one-cycle pop strobe to the RX FIFO.
- tx_full  in  1  TX FIFO full.
- w_data  out  8  TX FIFO write byte.
- wr_uart  out  1  one-cycle push strobe to the TX FIFO.
- reg_addr  out  4  register bank address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle register write strobe.
- reg_rdata  in  8  combinational register read data for reg_addr.
- frame_err  out  1  one-cycle pulse on NAK or timeout.
- busy  out  1  high in every state except HUNT.

Behaviour:
- Frame: SOF, CMD (bit7=1 write, bit6:4 ignored, bit3:0 addr), DATA (ignored for reads), CHK = CMD ^ DATA.
- Responses: good frame -> ACK then one data byte (reg_rdata for a read, the written DATA for a write); bad CHK -> NAK only; timeout -> no response.
- Reset: all outputs 0; state HUNT; internal cmd/data/timer cleared. Reset mid-frame or mid-response abandons it; partially sent responses are not completed.
- States:
  - HUNT: when rx_empty=0, pop. If r_data==SOF go to GET_CMD; otherwise stay (byte discarded).
  - GET_CMD: when rx_empty=0, pop, latch cmd, go to GET_DATA.
  - GET_DATA: when rx_empty=0, pop, latch data, go to GET_CHK.
  - GET_CHK: when rx_empty=0, pop. Go to EXEC if r_data==cmd^data, else SEND_NAK.
  - EXEC: exactly one cycle. reg_addr=cmd[3:0]. On write, assert reg_we with reg_wdata=data and set resp=data; on read, set resp=reg_rdata. Go to SEND_ACK.
  - SEND_ACK: wait for tx_full=0, push ACK, go to SEND_DATA.
  - SEND_DATA: wait for tx_full=0, push resp, go to HUNT.
  - SEND_NAK: wait for tx_full=0, push NAK, pulse frame_err, go to HUNT.
- rd_uart is asserted only in the same cycle as rx_empty=0, at most one pop per cycle. wr_uart is asserted only when tx_full=0.
- A SOF byte received in GET_CMD/GET_DATA/GET_CHK is treated as ordinary data; there is no resync mid-frame.
- reg_addr holds its last value outside EXEC. reg_we is never asserted for reads or NAK frames.
- Minimum latency: CHK pop to ACK push = 2 cycles (EXEC, then SEND_ACK) with TX not full.

Optional Feature:
- UART_CMD_TIMEOUT_EN defined: a timer runs in GET_CMD, GET_DATA and GET_CHK. It reloads on every pop and on leaving HUNT. When it reaches TIMEOUT_CYCLES with no byte, the block returns to HUNT and pulses frame_err; no TX output is produced. The timer is 23 bits for the default parameter.
- UART_CMD_TIMEOUT_EN undefined: no timer logic; the block waits indefinitely for frame bytes. frame_err pulses only on NAK.

Decomposition:
- Package uart_cmd_pkg: state enum (HUNT, GET_CMD, GET_DATA, GET_CHK, EXEC, SEND_ACK, SEND_DATA, SEND_NAK), default SOF/ACK/NAK constants, and CMD field bit positions.
- One natural sub-module: uart_cmd_timeout, a loadable down-counter with an expiry pulse, instantiated only under UART_CMD_TIMEOUT_EN.

Test Plan:
- Write frame A5 83 5C DF, TX never full -> one-cycle reg_we with addr=3 and wdata=5C; TX bytes 06 then 5C; busy falls back to 0.
- Read frame A5 02 00 02 with reg_rdata=0x7E -> reg_we stays 0; TX bytes 06 then 7E.
- Bad checksum A5 83 5C 00 -> no reg_we; TX byte 15 only; one frame_err pulse.
- Junk 00 FF 13 then a valid write frame -> the junk bytes are popped and discarded; the valid frame executes normally.
- tx_full held high for 20 cycles after EXEC -> wr_uart stays 0 throughout; ACK is pushed on the first cycle tx_full=0; no byte is lost or duplicated.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: send A5 83, then idle 150 cycles -> frame_err pulses at cycle 100; state is HUNT; no TX output; the next full frame succeeds.
